cordic_sequencer: RTL and testbench
===================================

// Module: cordic_sequencer
// PURPOSE
//  Control FSM for the CORDIC engine. Accepts one operation per request with a
//  valid/ready handshake, then pulses the datapath load and drives the
//  iteration enable. It also supplies the iteration index, which addresses the
//  arctangent ROM. The result is presented with a valid/ready handshake.
//  Sits between the host/bus interface and the CORDIC datapath + ROM.
// PARAMETERS
//  NITER   16  number of CORDIC iterations per operation (>=2)
//  ITER_W  5   width of iteration index; must satisfy 2**ITER_W >= NITER
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       host presents an operation
//  req_mode   in   1       0 = rotation, 1 = vectoring; sampled on accept
//  req_ready  out  1       sequencer can accept (high only in IDLE)
//  abort      in   1       synchronous cancel of the current operation
//  dp_load    out  1       one-cycle pulse: datapath captures initial x,y,z
//  dp_en      out  1       datapath performs one micro-rotation this cycle
//  dp_mode    out  1       latched mode, stable from LOAD until return to IDLE
//  iter       out  ITER_W  current iteration index / ATAN ROM address
//  res_valid  out  1       datapath outputs hold a finished result
//  res_ready  in   1       host consumes the result
//  busy       out  1       high in LOAD, ITER and DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, iter=0, dp_mode=0. Outputs: req_ready=1, and
//   dp_load, dp_en, res_valid and busy all 0. Outputs are Moore-decoded from
//   registered state.
//  States and transitions:
//   IDLE : req_ready=1. req_valid&req_ready -> LOAD; dp_mode<=req_mode.
//   LOAD : dp_load=1 for exactly one cycle; iter<=0 -> ITER.
//   ITER : dp_en=1; iter increments each cycle. At iter==NITER-1 -> DONE.
//          iter holds NITER-1. dp_en is high for exactly NITER cycles.
//   DONE : res_valid=1, held until res_valid&res_ready -> IDLE.
//          Datapath is frozen (dp_en=0).
//  Latency: accept at edge k -> dp_load in cycle k+1 -> dp_en in cycles
//   k+2 .. k+1+NITER -> res_valid from cycle k+2+NITER. Min 2+NITER cycles.
//  Throughput: a new request is accepted no earlier than the cycle after the
//   result handshake (one IDLE cycle minimum between operations).
//  req_valid while busy: ignored, not queued. req_mode is not re-sampled.
//  res_ready in the first DONE cycle: DONE lasts one cycle.
//  res_ready outside DONE: no effect.
//  abort: highest priority, any non-IDLE state -> IDLE at next edge.
//   No res_valid; iter<=0; dp_load/dp_en deassert immediately next cycle.
//   abort in IDLE is a no-op. abort together with req_valid in IDLE: the
//   request is not accepted.
//  Reset asserted mid-operation: immediate return to reset values; no pulse
//   or result is emitted.
//  iter never wraps: it is held at NITER-1 in DONE, and 0 in IDLE/LOAD.
// STRUCTURE
//  Shared package cordic_pkg holds:
//   - state encodings S_IDLE, S_LOAD, S_ITER, S_DONE (2-bit);
//   - MODE_ROT=0 and MODE_VEC=1;
//   - default NITER and ITER_W.
//  One sub-module is natural: cordic_iter_cnt, a loadable up-counter with
//   clear/enable and terminal-count flag (iter==NITER-1).
//  The FSM and output decode stay in this module.
// TESTING
//  1 Reset then idle: req_ready=1, busy=0, iter=0 and all pulses 0 for 10
//    cycles with no request.
//  2 Single rotation op (mode=0, res_ready=1): dp_load high 1 cycle; dp_en
//    high 16 cycles with iter 0..15; res_valid at accept+18; DONE lasts 1
//    cycle; req_ready back 1 cycle later.
//  3 Back-pressure: res_ready=0 for 7 cycles in DONE -> res_valid and iter=15
//    held, dp_en=0. req_valid=1 throughout is not accepted until after the
//    handshake.
//  4 Abort at iter=9 -> IDLE next cycle, res_valid never rises. A following
//    vectoring request completes normally with dp_mode=1.
//  5 Async reset pulse at iter=5 between clock edges -> outputs reach reset
//    values before the next edge. No dp_load or res_valid follows.
//  6 Param NITER=4, ITER_W=2: dp_en 4 cycles, iter 0..3, res_valid at
//    accept+6.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC control slice.
//   state_e        : sequencer state encoding (2-bit)
//   MODE_ROT/VEC   : operation mode values carried on req_mode / dp_mode
//   NITER_DEFAULT  : default number of micro-rotations per operation
//   ITER_W_DEFAULT : default width of the iteration index / ATAN ROM address
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam int NITER_DEFAULT  = 16;
  localparam int ITER_W_DEFAULT = 5;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration counter for the CORDIC sequencer.
// Up-counter with synchronous clear (which takes priority) and count enable.
// tc_o flags the last iteration (iter_o == NITER-1).
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   clear_i      : force the count to 0 at the next edge
//   en_i         : advance the count by one at the next edge
//   iter_o       : current iteration index
//   tc_o         : terminal count reached
module cordic_iter_cnt #(
  parameter int NITER  = 16,
  parameter int ITER_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  output logic [ITER_W-1:0] iter_o,
  output logic              tc_o
);

  localparam logic [ITER_W-1:0] LAST = ITER_W'(NITER - 1);

  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_d;

  // Clear wins over enable so an abort can never leave a stale index behind.
  always_comb begin
    iter_d = iter_q;
    if (clear_i) begin
      iter_d = '0;
    end else if (en_i) begin
      iter_d = iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign iter_o = iter_q;
  assign tc_o   = (iter_q == LAST);

endmodule

// File: rtl/cordic_sequencer.sv
// Control FSM for the CORDIC engine.
// Accepts one operation per valid/ready request, pulses the datapath load,
// runs NITER micro-rotations while supplying the ATAN ROM address, then holds
// the result until the host consumes it. Outputs are Moore-decoded.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   req_valid/req_ready  : request handshake; req_mode sampled on accept
//   abort                : synchronous cancel of a running operation
//   dp_load              : one-cycle datapath initial-value capture
//   dp_en                : datapath performs a micro-rotation this cycle
//   dp_mode              : mode latched at accept (0 rotation, 1 vectoring)
//   iter                 : iteration index / ATAN ROM address
//   res_valid/res_ready  : result handshake
//   busy                 : operation in progress (LOAD, ITER, DONE)
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int NITER  = NITER_DEFAULT,
  parameter int ITER_W = ITER_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_mode,
  output logic              req_ready,
  input  logic              abort,
  output logic              dp_load,
  output logic              dp_en,
  output logic              dp_mode,
  output logic [ITER_W-1:0] iter,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   accept;
  logic   cntClear;
  logic   cntEn;
  logic   lastIter;

  // Abort in IDLE also blocks acceptance of a simultaneous request.
  assign accept = (state_q == S_IDLE) && req_valid && !abort;

  // Next-state logic; abort overrides every non-IDLE transition.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          mode_d  = req_mode;
        end
      end
      S_LOAD: state_d = S_ITER;
      S_ITER: if (lastIter) state_d = S_DONE;
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ROT;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Clearing on the upcoming state keeps iter at 0 from the very first
  // IDLE/LOAD cycle, including right after a result handshake or abort.
  // Counting stops at the terminal value so DONE holds NITER-1.
  assign cntClear = (state_d == S_IDLE) || (state_d == S_LOAD);
  assign cntEn    = (state_q == S_ITER) && !lastIter;

  cordic_iter_cnt #(
    .NITER  (NITER),
    .ITER_W (ITER_W)
  ) u_iter_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear_i (cntClear),
    .en_i    (cntEn),
    .iter_o  (iter),
    .tc_o    (lastIter)
  );

  // Moore output decode from the registered state.
  always_comb begin
    req_ready = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_LOAD: begin
        dp_load = 1'b1;
        busy    = 1'b1;
      end
      S_ITER: begin
        dp_en = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign dp_mode = mode_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: a table-driven single operation,
// hand-written corner sequences (back-pressure, abort, async reset, NITER=4),
// then random traffic against a cycle-count reference model.
module tb_cordic_sequencer;

  typedef struct {
    bit reqReady;
    bit dpLoad;
    bit dpEn;
    bit dpMode;
    bit resValid;
    bit busy;
    int iter;
  } outs_t;

  typedef struct {
    bit    rv;
    bit    rm;
    bit    ab;
    bit    rr;
    outs_t exp;
  } vec_t;

  // Model state: whether an operation is in flight and how many cycles have
  // elapsed since its accept edge (1 = load cycle).
  typedef struct {
    bit active;
    int t;
    bit mode;
  } model_t;

  logic       clock;
  logic       reset;

  logic       rv16, rm16, ab16, rr16;
  logic       reqReady16, dpLoad16, dpEn16, dpMode16, resValid16, busy16;
  logic [4:0] iter16;

  logic       rv4, rm4, ab4, rr4;
  logic       reqReady4, dpLoad4, dpEn4, dpMode4, resValid4, busy4;
  logic [1:0] iter4;

  int checkCount = 0;
  int passCount  = 0;

  cordic_sequencer dut16 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (rv16),
    .req_mode  (rm16),
    .req_ready (reqReady16),
    .abort     (ab16),
    .dp_load   (dpLoad16),
    .dp_en     (dpEn16),
    .dp_mode   (dpMode16),
    .iter      (iter16),
    .res_valid (resValid16),
    .res_ready (rr16),
    .busy      (busy16)
  );

  cordic_sequencer #(.NITER(4), .ITER_W(2)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (rv4),
    .req_mode  (rm4),
    .req_ready (reqReady4),
    .abort     (ab4),
    .dp_load   (dpLoad4),
    .dp_en     (dpEn4),
    .dp_mode   (dpMode4),
    .iter      (iter4),
    .res_valid (resValid4),
    .res_ready (rr4),
    .busy      (busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic outs_t mkOuts(bit rq, bit ld, bit en, bit md, bit rvl, bit bs, int it);
    outs_t o;
    o.reqReady = rq;
    o.dpLoad   = ld;
    o.dpEn     = en;
    o.dpMode   = md;
    o.resValid = rvl;
    o.busy     = bs;
    o.iter     = it;
    return o;
  endfunction

  function automatic vec_t mkVec(bit rv, bit rm, bit ab, bit rr, outs_t e);
    vec_t v;
    v.rv  = rv;
    v.rm  = rm;
    v.ab  = ab;
    v.rr  = rr;
    v.exp = e;
    return v;
  endfunction

  function automatic outs_t sample16();
    return mkOuts(reqReady16, dpLoad16, dpEn16, dpMode16, resValid16, busy16, int'(iter16));
  endfunction

  function automatic outs_t sample4();
    return mkOuts(reqReady4, dpLoad4, dpEn4, dpMode4, resValid4, busy4, int'(iter4));
  endfunction

  // Expected outputs from the elapsed-cycle view of an operation:
  // t=1 load, t=2..niter+1 micro-rotations, t>=niter+2 result held.
  function automatic outs_t modelOut(model_t m, int niter);
    outs_t o;
    o = mkOuts(!m.active, 0, 0, m.mode, 0, m.active, 0);
    if (m.active) begin
      if (m.t == 1) begin
        o.dpLoad = 1;
      end else if (m.t <= niter + 1) begin
        o.dpEn = 1;
        o.iter = m.t - 2;
      end else begin
        o.resValid = 1;
        o.iter     = niter - 1;
      end
    end
    return o;
  endfunction

  function automatic model_t modelStep(model_t m, int niter, bit rv, bit rm, bit ab, bit rr);
    model_t n = m;
    if (!m.active) begin
      if (rv && !ab) begin
        n.active = 1;
        n.t      = 1;
        n.mode   = rm;
      end
    end else if (ab) begin
      n.active = 0;
    end else if (m.t >= niter + 2) begin
      if (rr) n.active = 0;
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOuts(string tag, outs_t act, outs_t exp);
    checkOutput({tag, ".req_ready"}, act.reqReady, exp.reqReady);
    checkOutput({tag, ".dp_load"},   act.dpLoad,   exp.dpLoad);
    checkOutput({tag, ".dp_en"},     act.dpEn,     exp.dpEn);
    checkOutput({tag, ".res_valid"}, act.resValid, exp.resValid);
    checkOutput({tag, ".busy"},      act.busy,     exp.busy);
    checkOutput({tag, ".iter"},      act.iter,     exp.iter);
    if (exp.busy) checkOutput({tag, ".dp_mode"}, act.dpMode, exp.dpMode);
  endtask

  task automatic applyStimulus(bit rv, bit rm, bit ab, bit rr);
    rv16 = rv;
    rm16 = rm;
    ab16 = ab;
    rr16 = rr;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    vec_t   vecs[$];
    outs_t  idle;
    model_t m16, m4;
    bit     sawLoad, sawValid;

    idle = mkOuts(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) vecs.push_back(mkVec(0, 0, 0, 0, idle));
    vecs.push_back(mkVec(1, 0, 0, 1, idle));
    vecs.push_back(mkVec(0, 0, 0, 1, mkOuts(0, 1, 0, 0, 0, 1, 0)));
    for (int i = 0; i < 16; i++) vecs.push_back(mkVec(0, 0, 0, 1, mkOuts(0, 0, 1, 0, 0, 1, i)));
    vecs.push_back(mkVec(0, 0, 0, 1, mkOuts(0, 0, 0, 0, 1, 1, 15)));
    vecs.push_back(mkVec(0, 0, 0, 0, idle));

    applyStimulus(0, 0, 0, 0);
    rv4 = 0; rm4 = 0; ab4 = 0; rr4 = 0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset/idle and one rotation operation, one record per cycle.
    checkOutput("reset.dp_mode", dpMode16, 0);
    foreach (vecs[i]) begin
      checkOuts($sformatf("table[%0d]", i), sample16(), vecs[i].exp);
      applyStimulus(vecs[i].rv, vecs[i].rm, vecs[i].ab, vecs[i].rr);
      stepCycle();
    end

    // Back-pressure: result held, request not accepted nor mode re-sampled.
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    rm16 = 1;
    checkOutput("bp.load", dpLoad16, 1);
    repeat (17) stepCycle();
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp.res_valid", resValid16, 1);
      checkOutput("bp.iter", iter16, 15);
      checkOutput("bp.dp_en", dpEn16, 0);
      checkOutput("bp.req_ready", reqReady16, 0);
      checkOutput("bp.dp_mode", dpMode16, 0);
      stepCycle();
    end
    checkOutput("bp.still_valid", resValid16, 1);
    rr16 = 1;
    stepCycle();
    checkOutput("bp.idle_ready", reqReady16, 1);
    checkOutput("bp.idle_busy", busy16, 0);
    checkOutput("bp.idle_iter", iter16, 0);
    stepCycle();
    checkOutput("bp.reaccept_load", dpLoad16, 1);
    checkOutput("bp.reaccept_mode", dpMode16, 1);
    applyStimulus(0, 0, 1, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 1);

    // Abort at iter 9, then abort-with-request in IDLE, then a vectoring op.
    applyStimulus(1, 0, 0, 1);
    stepCycle();
    rv16 = 0;
    repeat (10) stepCycle();
    checkOutput("abort.pre_iter", iter16, 9);
    ab16 = 1;
    stepCycle();
    ab16 = 0;
    checkOutput("abort.busy", busy16, 0);
    checkOutput("abort.iter", iter16, 0);
    checkOutput("abort.dp_en", dpEn16, 0);
    checkOutput("abort.req_ready", reqReady16, 1);
    sawValid = 0;
    for (int i = 0; i < 20; i++) begin
      if (resValid16) sawValid = 1;
      stepCycle();
    end
    checkOutput("abort.no_result", sawValid, 0);
    applyStimulus(1, 1, 1, 1);
    stepCycle();
    checkOutput("abort_idle.busy", busy16, 0);
    checkOutput("abort_idle.dp_load", dpLoad16, 0);
    applyStimulus(1, 1, 0, 1);
    stepCycle();
    rv16 = 0;
    checkOutput("vec.load", dpLoad16, 1);
    repeat (17) stepCycle();
    checkOutput("vec.res_valid", resValid16, 1);
    checkOutput("vec.dp_mode", dpMode16, 1);
    checkOutput("vec.iter", iter16, 15);
    stepCycle();
    checkOutput("vec.back_idle", reqReady16, 1);

    // Async reset between edges at iter 5.
    applyStimulus(1, 1, 0, 1);
    stepCycle();
    rv16 = 0;
    repeat (6) stepCycle();
    checkOutput("arst.pre_iter", iter16, 5);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst.iter", iter16, 0);
    checkOutput("arst.busy", busy16, 0);
    checkOutput("arst.req_ready", reqReady16, 1);
    checkOutput("arst.dp_en", dpEn16, 0);
    checkOutput("arst.dp_mode", dpMode16, 0);
    #1 reset = 1'b0;
    @(negedge clock);
    sawLoad  = 0;
    sawValid = 0;
    for (int i = 0; i < 20; i++) begin
      if (dpLoad16) sawLoad = 1;
      if (resValid16) sawValid = 1;
      stepCycle();
    end
    checkOutput("arst.no_load", sawLoad, 0);
    checkOutput("arst.no_result", sawValid, 0);

    // NITER=4 instance.
    rv4 = 1; rm4 = 0; rr4 = 1;
    stepCycle();
    rv4 = 0;
    checkOutput("n4.load", dpLoad4, 1);
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      checkOutput("n4.dp_en", dpEn4, 1);
      checkOutput("n4.iter", iter4, c);
    end
    stepCycle();
    checkOutput("n4.res_valid", resValid4, 1);
    checkOutput("n4.iter_hold", iter4, 3);
    stepCycle();
    checkOutput("n4.back_idle", reqReady4, 1);

    // Random traffic on both instances against the reference model.
    m16 = '{active: 0, t: 0, mode: 0};
    m4  = '{active: 0, t: 0, mode: 0};
    for (int n = 0; n < 2000; n++) begin
      checkOuts("rnd16", sample16(), modelOut(m16, 16));
      checkOuts("rnd4", sample4(), modelOut(m4, 4));
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)));
      rv4 = $urandom_range(0, 3) != 0;
      rm4 = 1'($urandom_range(0, 1));
      ab4 = $urandom_range(0, 29) == 0;
      rr4 = 1'($urandom_range(0, 1));
      m16 = modelStep(m16, 16, rv16, rm16, ab16, rr16);
      m4  = modelStep(m4, 4, rv4, rm4, ab4, rr4);
      stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
